// File: rtl/alu_op_sequencer.sv
// Operator-driven sequencer for the 4-bit ALU: steps A, B and opcode in from switches, waits
// for the ALU to settle, then captures and holds result/flags. Optional macro: ALU_SEQ_CHAIN_EN.
module alu_op_sequencer #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned OP_MAX        = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_next,
    input  logic             btn_clr,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags,
    output logic             err,
    output logic             done,
    output logic [2:0]       state_o
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ST_W   = 3;

    typedef enum logic [ST_W-1:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t           state;
    logic             btn_prev;
    logic [CNT_W-1:0] settle_cnt;

    logic press_c;
    logic op_illegal_c;
    logic settle_last_c;

    // One press per rising edge of the level button, however long it is held
    assign press_c       = btn_next & ~btn_prev;
    assign op_illegal_c  = 32'(sw) > OP_MAX;
    // The counter holds (cycles already spent in EXEC); the entry cycle sees zero
    assign settle_last_c = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_A;
            btn_prev   <= 1'b0;
            settle_cnt <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            res        <= '0;
            flags      <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
        end else begin
            btn_prev <= btn_next;
            done     <= 1'b0;

            case (state)
                LOAD_A: begin
                    if (btn_clr) begin
                        state <= LOAD_A;
                    end else if (press_c) begin
                        alu_a <= sw;
                        state <= LOAD_B;
                    end
                end

                LOAD_B: begin
                    if (btn_clr) begin
                        state <= LOAD_A;
                    end else if (press_c) begin
                        alu_b <= sw;
                        state <= LOAD_OP;
                    end
                end

                LOAD_OP: begin
                    if (btn_clr) begin
                        state <= LOAD_A;
                    end else if (press_c) begin
                        alu_op <= OP_W'(sw);
                        if (op_illegal_c) begin
                            // Illegal opcode never reaches the ALU capture path
                            res   <= '0;
                            flags <= '0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= SHOW;
                        end else begin
                            settle_cnt <= '0;
                            state      <= EXEC;
                        end
                    end
                end

                // Operands held; buttons ignored so a capture is never partial
                EXEC: begin
                    settle_cnt <= settle_cnt + CNT_W'(1);
                    if (settle_last_c) begin
                        res   <= alu_y;
                        flags <= FLAG_W'({alu_n, alu_z, alu_c, alu_v});
                        err   <= 1'b0;
                        done  <= 1'b1;
                        state <= SHOW;
                    end
                end

                SHOW: begin
                    if (btn_clr) begin
                        state <= LOAD_A;
                    end else if (press_c) begin
`ifdef ALU_SEQ_CHAIN_EN
                        if (!err) begin
                            alu_a <= res;
                            state <= LOAD_B;
                        end else begin
                            state <= LOAD_A;
                        end
`else
                        state <= LOAD_A;
`endif
                    end
                end

                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

endmodule
